// File: rtl/ram_pkg.sv
// Shared definitions for the banked RAM: default geometry, FSM state encoding
// and a constant-evaluable clog2 used to derive address widths.
package ram_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_BANKS  = 2;

    localparam int STATE_W = 1;
    typedef logic [STATE_W-1:0] state_t;

    localparam logic [STATE_W-1:0] ST_INIT  = 1'b0;
    localparam logic [STATE_W-1:0] ST_READY = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ram_bank.sv
// One bank of the banked RAM: synchronous write port and a registered read port
// that samples raddr on every rising edge.
module ram_bank
    import ram_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH / DEF_BANKS,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Read-side next value: the word currently addressed.
    always_comb begin
        rdata_d = mem_q[raddr];
    end

    // Storage array write and read-data register.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_banked.sv
// Banked synchronous RAM with a power-on/clear sweep that zeroes every bank in
// parallel, a one-cycle registered read path and a read-valid strobe.
module ram_banked
    import ram_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    parameter  int BANKS  = DEF_BANKS,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              req_valid,
    input  logic              rw,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy
);

    localparam int BANK_W     = clog2(BANKS);
    localparam int BANK_DEPTH = DEPTH / BANKS;
    localparam int OFF_W      = ADDR_W - BANK_W;
    localparam logic [OFF_W-1:0] LAST_PTR = OFF_W'(BANK_DEPTH - 1);

    state_t            state_q,     state_d;
    logic [OFF_W-1:0]  sweep_ptr_q, sweep_ptr_d;
    logic              busy_q,      busy_d;
    logic              rd_valid_q,  rd_valid_d;
    logic [BANK_W-1:0] rd_bank_q,   rd_bank_d;
    logic [DATA_W-1:0] hold_q,      hold_d;

    logic [BANK_W-1:0] bank_sel_s;
    logic [OFF_W-1:0]  offset_s;
    logic              accept_s;
    logic              wr_s;
    logic              rd_s;
    logic [BANKS-1:0]  we_s;
    logic [OFF_W-1:0]  waddr_s;
    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] rdata_s [BANKS];

    // Request decode: requests are dropped while sweeping or while clear is high.
    always_comb begin
        bank_sel_s = address[ADDR_W-1 -: BANK_W];
        offset_s   = address[OFF_W-1:0];
        accept_s   = req_valid & ~busy_q & ~clear;
        wr_s       = accept_s & rw;
        rd_s       = accept_s & ~rw;
    end

    // Bank write steering: the sweep writes all banks at once, otherwise one bank.
    always_comb begin
        we_s    = {BANKS{1'b0}};
        waddr_s = offset_s;
        wdata_s = data_in;
        if (state_q == ST_INIT) begin
            waddr_s = sweep_ptr_q;
            wdata_s = {DATA_W{1'b0}};
            for (int b = 0; b < BANKS; b++) begin
                we_s[b] = ~clear;
            end
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                we_s[b] = wr_s & (bank_sel_s == BANK_W'(b));
            end
        end
    end

    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        ram_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (BANK_DEPTH)
        ) u_bank (
            .clock (clock),
            .we    (we_s[g]),
            .waddr (waddr_s),
            .wdata (wdata_s),
            .raddr (offset_s),
            .rdata (rdata_s[g])
        );
    end

    // Output mux: fresh bank data on the cycle after a read, held value otherwise.
    always_comb begin
        if (rd_valid_q) begin
            data_out = rdata_s[rd_bank_q];
        end else begin
            data_out = hold_q;
        end
    end

    // Next-state logic for the sweep FSM and the read-tracking registers.
    always_comb begin
        state_d     = state_q;
        sweep_ptr_d = sweep_ptr_q;
        busy_d      = busy_q;
        rd_valid_d  = rd_s;
        rd_bank_d   = rd_s ? bank_sel_s : rd_bank_q;
        hold_d      = data_out;
        if (clear) begin
            state_d     = ST_INIT;
            sweep_ptr_d = {OFF_W{1'b0}};
            busy_d      = 1'b1;
            rd_valid_d  = 1'b0;
            rd_bank_d   = {BANK_W{1'b0}};
            hold_d      = {DATA_W{1'b0}};
        end else begin
            case (state_q)
                ST_INIT: begin
                    sweep_ptr_d = sweep_ptr_q + {{(OFF_W-1){1'b0}}, 1'b1};
                    if (sweep_ptr_q == LAST_PTR) begin
                        state_d = ST_READY;
                        busy_d  = 1'b0;
                    end else begin
                        busy_d  = 1'b1;
                    end
                end
                ST_READY: begin
                    busy_d = 1'b0;
                end
                default: begin
                    state_d     = ST_INIT;
                    sweep_ptr_d = {OFF_W{1'b0}};
                    busy_d      = 1'b1;
                end
            endcase
        end
    end

    // State registers; clear is a synchronous reset.
    always_ff @(posedge clock) begin
        state_q     <= state_d;
        sweep_ptr_q <= sweep_ptr_d;
        busy_q      <= busy_d;
        rd_valid_q  <= rd_valid_d;
        rd_bank_q   <= rd_bank_d;
        hold_q      <= hold_d;
    end

    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;

endmodule
